// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: serializes one packet descriptor (PID byte, then token
// or data fields) LSB-first into the CRC encoder, waits for the CRC tail to
// drain and reports completion or a CRC timeout.
module usb_tx_sequencer #(
    parameter int DATA_BITS   = 64,
    parameter int CRC_TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic                 pkt_valid,
    output logic                 pkt_ready,
    input  logic [1:0]           pkt_kind,
    input  logic [3:0]           pid,
    input  logic [6:0]           addr,
    input  logic [3:0]           endp,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 stall,
    input  logic                 crc_sending,
    output logic                 ser_bit,
    output logic                 ser_recving,
    output logic                 ser_start,
    output logic                 ser_pkttype,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 crc_err
);

    // Bit counter covers the widest field (64 data bits); the CRC wait
    // counter is 5 bits wide.
    localparam int CNT_W = 7;
    localparam int TMO_W = 5;
    localparam int DI_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_FIELD,
        S_CRC_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [CNT_W-1:0]      r_cnt;
    logic [TMO_W-1:0]      r_tcnt;
    logic [1:0]            r_kind;
    logic [3:0]            r_pid;
    logic [6:0]            r_addr;
    logic [3:0]            r_endp;
    logic [DATA_BITS-1:0]  r_data;

    logic                  w_accept;
    logic                  w_isData;
    logic                  w_isHandshake;
    logic [7:0]            w_pidByte;
    logic [15:0]           w_tokenField;
    logic [CNT_W-1:0]      w_fieldLast;
    logic                  w_pidLast;
    logic                  w_fieldEnd;
    logic                  w_crcExit;
    logic                  w_timeout;

    assign w_accept      = pkt_valid && (r_state == S_IDLE);
    assign w_isData      = (r_kind == 2'b01);
    assign w_isHandshake = r_kind[1];
    assign w_pidByte     = {~r_pid, r_pid};
    assign w_tokenField  = {5'b0, r_endp, r_addr};
    assign w_fieldLast   = w_isData ? CNT_W'(DATA_BITS - 1) : CNT_W'(10);
    assign w_pidLast     = (r_cnt == CNT_W'(7));
    assign w_fieldEnd    = (r_cnt == w_fieldLast);
    // The first CRC_WAIT cycle (counter still 0) never exits; a finished
    // encoder wins over a simultaneous timeout.
    assign w_crcExit     = (r_tcnt != '0) && !crc_sending;
    assign w_timeout     = (r_tcnt == TMO_W'(CRC_TIMEOUT - 1)) && !w_crcExit;

    // State register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic; stall freezes every state except IDLE and DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (pkt_valid) w_nextState = S_PID;
            S_PID:      if (!stall && w_pidLast)
                            w_nextState = w_isHandshake ? S_DONE : S_FIELD;
            S_FIELD:    if (!stall && w_fieldEnd) w_nextState = S_CRC_WAIT;
            S_CRC_WAIT: if (!stall) begin
                            if (w_crcExit)      w_nextState = S_DONE;
                            else if (w_timeout) w_nextState = S_IDLE;
                        end
            S_DONE:     w_nextState = S_IDLE;
            default:    w_nextState = S_IDLE;
        endcase
    end

    // Bit and timeout counters advance only on unstalled cycles.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_cnt  <= '0;
            r_tcnt <= '0;
        end else begin
            case (r_state)
                S_PID: if (!stall) r_cnt <= w_pidLast ? '0 : r_cnt + 1'b1;
                S_FIELD: if (!stall) begin
                    r_cnt  <= w_fieldEnd ? '0 : r_cnt + 1'b1;
                    r_tcnt <= '0;
                end
                S_CRC_WAIT: if (!stall) r_tcnt <= r_tcnt + 1'b1;
                default: begin
                    r_cnt  <= '0;
                    r_tcnt <= '0;
                end
            endcase
        end
    end

    // Descriptor latch, captured on the accepting handshake.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_kind <= '0;
            r_pid  <= '0;
            r_addr <= '0;
            r_endp <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_kind <= pkt_kind;
            r_pid  <= pid;
            r_addr <= addr;
            r_endp <= endp;
            r_data <= data;
        end
    end

    // Outputs decode from state and counter, so they hold naturally while stalled.
    always_comb begin
        pkt_ready   = 1'b0;
        ser_bit     = 1'b0;
        ser_recving = 1'b0;
        ser_start   = 1'b0;
        ser_pkttype = 1'b0;
        busy        = 1'b1;
        pkt_done    = 1'b0;
        crc_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                pkt_ready = 1'b1;
                busy      = 1'b0;
            end
            S_PID: begin
                ser_bit     = w_pidByte[r_cnt[2:0]];
                ser_recving = 1'b1;
                ser_start   = 1'b1;
                ser_pkttype = w_isData;
            end
            S_FIELD: begin
                ser_bit     = w_isData ? r_data[r_cnt[DI_W-1:0]]
                                       : w_tokenField[r_cnt[3:0]];
                ser_recving = 1'b1;
                ser_pkttype = w_isData;
            end
            S_CRC_WAIT: begin
                ser_pkttype = w_isData;
                crc_err     = !stall && w_timeout;
            end
            S_DONE: pkt_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed testbench for usb_tx_sequencer: each task drives one scenario
// and compares outputs against hand-computed values at the falling edge.
module tb_usb_tx_sequencer;

    logic        clk;
    logic        rst_L;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [1:0]  pkt_kind;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        stall;
    logic        crc_sending;
    logic        ser_bit;
    logic        ser_recving;
    logic        ser_start;
    logic        ser_pkttype;
    logic        busy;
    logic        pkt_done;
    logic        crc_err;

    int nVec = 0;
    int nBad = 0;

    usb_tx_sequencer #(.DATA_BITS(64), .CRC_TIMEOUT(31)) dut (
        .clk(clk), .rst_L(rst_L), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_kind(pkt_kind), .pid(pid), .addr(addr), .endp(endp), .data(data),
        .stall(stall), .crc_sending(crc_sending), .ser_bit(ser_bit),
        .ser_recving(ser_recving), .ser_start(ser_start), .ser_pkttype(ser_pkttype),
        .busy(busy), .pkt_done(pkt_done), .crc_err(crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one descriptor in IDLE; returns on the first PID bit cycle with
    // the descriptor inputs scrubbed so the DUT must use its latched copy.
    task automatic sendDesc(input logic [1:0] k, input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input logic [63:0] d);
        nVec++;
        if (pkt_ready !== 1'b1) begin nBad++; $display("FAIL accept_ready: got %b expected 1", pkt_ready); end
        pkt_valid = 1'b1; pkt_kind = k; pid = p; addr = a; endp = e; data = d;
        @(negedge clk);
        pkt_valid = 1'b0; pkt_kind = '0; pid = '0; addr = '0; endp = '0; data = '0;
    endtask

    // Records n consecutive cycles of the serial outputs (bit i = cycle i).
    task automatic collect(input int n, output logic [127:0] b, output logic [127:0] s,
                           output logic [127:0] r, output logic [127:0] t);
        b = '0; s = '0; r = '0; t = '0;
        for (int i = 0; i < n; i++) begin
            b[i] = ser_bit; s[i] = ser_start; r[i] = ser_recving; t[i] = ser_pkttype;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_L = 1'b0; pkt_valid = 1'b0; pkt_kind = '0; pid = '0; addr = '0; endp = '0;
        data = '0; stall = 1'b0; crc_sending = 1'b0;
        repeat (2) @(negedge clk);
        nVec++;
        if ({pkt_ready, busy, ser_bit, ser_recving, ser_start, ser_pkttype, pkt_done, crc_err} !== 8'b1000_0000) begin
            nBad++; $display("FAIL reset_outputs: got %b expected 10000000",
                {pkt_ready, busy, ser_bit, ser_recving, ser_start, ser_pkttype, pkt_done, crc_err});
        end
        rst_L = 1'b1;
        @(negedge clk);
        nVec++;
        if ({pkt_ready, busy, pkt_done, crc_err} !== 4'b1000) begin
            nBad++; $display("FAIL reset_release: got %b expected 1000", {pkt_ready, busy, pkt_done, crc_err});
        end
    endtask

    task automatic test_token();
        logic [127:0] b, s, r, t, expB;
        logic sawDone;
        crc_sending = 1'b1;
        sendDesc(2'b00, 4'b0001, 7'h05, 4'h1, 64'h0);
        collect(19, b, s, r, t);
        expB = '0; expB[18:0] = {4'h1, 7'h05, 4'b1110, 4'b0001};
        nVec++; if (b !== expB) begin nBad++; $display("FAIL token_bits: got %h expected %h", b, expB); end
        nVec++; if (s !== 128'hFF) begin nBad++; $display("FAIL token_start: got %h expected ff", s); end
        nVec++; if (r !== 128'h7FFFF) begin nBad++; $display("FAIL token_recving: got %h expected 7ffff", r); end
        nVec++; if (t !== 128'h0) begin nBad++; $display("FAIL token_pkttype: got %h expected 0", t); end
        nVec++;
        if ({ser_recving, ser_start, ser_bit, busy} !== 4'b0001) begin
            nBad++; $display("FAIL token_crcwait: got %b expected 0001", {ser_recving, ser_start, ser_bit, busy});
        end
        sawDone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sawDone |= pkt_done;
            @(negedge clk);
        end
        nVec++; if (sawDone !== 1'b0) begin nBad++; $display("FAIL token_early_done: got %b expected 0", sawDone); end
        crc_sending = 1'b0;
        @(negedge clk);
        nVec++;
        if ({pkt_done, pkt_ready} !== 2'b10) begin
            nBad++; $display("FAIL token_done: got %b expected 10", {pkt_done, pkt_ready});
        end
        @(negedge clk);
        nVec++;
        if ({pkt_done, pkt_ready, busy} !== 3'b010) begin
            nBad++; $display("FAIL token_idle: got %b expected 010", {pkt_done, pkt_ready, busy});
        end
    endtask

    task automatic test_data();
        logic [127:0] b, s, r, t, expB, expOnes;
        crc_sending = 1'b1;
        sendDesc(2'b01, 4'b0011, 7'h00, 4'h0, 64'h0123_4567_89AB_CDEF);
        collect(72, b, s, r, t);
        expB = '0; expB[71:0] = {64'h0123_4567_89AB_CDEF, 4'b1100, 4'b0011};
        expOnes = '0; expOnes[71:0] = {72{1'b1}};
        nVec++; if (b !== expB) begin nBad++; $display("FAIL data_bits: got %h expected %h", b, expB); end
        nVec++; if (s !== 128'hFF) begin nBad++; $display("FAIL data_start: got %h expected ff", s); end
        nVec++; if (r !== expOnes) begin nBad++; $display("FAIL data_recving: got %h expected %h", r, expOnes); end
        nVec++; if (t !== expOnes) begin nBad++; $display("FAIL data_pkttype: got %h expected %h", t, expOnes); end
        nVec++;
        if ({ser_recving, ser_pkttype, busy} !== 3'b011) begin
            nBad++; $display("FAIL data_crcwait: got %b expected 011", {ser_recving, ser_pkttype, busy});
        end
        crc_sending = 1'b0;
        @(negedge clk);
        nVec++;
        if ({busy, pkt_done} !== 2'b10) begin
            nBad++; $display("FAIL data_crc_first_cycle: got %b expected 10", {busy, pkt_done});
        end
        @(negedge clk);
        nVec++; if (pkt_done !== 1'b1) begin nBad++; $display("FAIL data_done: got %b expected 1", pkt_done); end
        @(negedge clk);
    endtask

    task automatic test_handshake();
        logic [127:0] b, s, r, t;
        crc_sending = 1'b0;
        sendDesc(2'b10, 4'b0010, 7'h00, 4'h0, 64'h0);
        collect(8, b, s, r, t);
        nVec++; if (b !== 128'hD2) begin nBad++; $display("FAIL hs_bits: got %h expected d2", b); end
        nVec++; if (s !== 128'hFF) begin nBad++; $display("FAIL hs_start: got %h expected ff", s); end
        nVec++; if (r !== 128'hFF) begin nBad++; $display("FAIL hs_recving: got %h expected ff", r); end
        nVec++;
        if ({pkt_done, ser_start, ser_recving} !== 3'b100) begin
            nBad++; $display("FAIL hs_done_cycle10: got %b expected 100", {pkt_done, ser_start, ser_recving});
        end
        stall = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        nVec++;
        if ({pkt_ready, busy, pkt_done} !== 3'b100) begin
            nBad++; $display("FAIL hs_done_ignores_stall: got %b expected 100", {pkt_ready, busy, pkt_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] b, s, r, t;
        pkt_valid = 1'b1; pkt_kind = 2'b11; pid = 4'b1010;
        @(negedge clk);
        nVec++; if (pkt_ready !== 1'b0) begin nBad++; $display("FAIL b2b_ready_busy: got %b expected 0", pkt_ready); end
        collect(8, b, s, r, t);
        nVec++; if (b !== 128'h5A) begin nBad++; $display("FAIL b2b_bits_first: got %h expected 5a", b); end
        nVec++;
        if ({pkt_done, pkt_ready} !== 2'b10) begin
            nBad++; $display("FAIL b2b_done_not_ready: got %b expected 10", {pkt_done, pkt_ready});
        end
        @(negedge clk);
        nVec++;
        if ({pkt_ready, busy} !== 2'b10) begin
            nBad++; $display("FAIL b2b_idle_after_done: got %b expected 10", {pkt_ready, busy});
        end
        @(negedge clk);
        pkt_valid = 1'b0; pkt_kind = '0; pid = '0;
        collect(8, b, s, r, t);
        nVec++; if (b !== 128'h5A) begin nBad++; $display("FAIL b2b_bits_second: got %h expected 5a", b); end
        nVec++; if (pkt_done !== 1'b1) begin nBad++; $display("FAIL b2b_done_second: got %b expected 1", pkt_done); end
        @(negedge clk);
    endtask

    task automatic test_token_stall();
        logic [127:0] b, s, r, expB;
        int idx;
        int held;
        crc_sending = 1'b0;
        expB = '0; expB[18:0] = {4'h1, 7'h05, 4'b1110, 4'b0001};
        sendDesc(2'b00, 4'b0001, 7'h05, 4'h1, 64'h0);
        b = '0; s = '0; r = '0; idx = 0; held = 0;
        for (int cyc = 0; cyc < 40 && idx < 19; cyc++) begin
            if (idx == 12 && held < 3) begin
                stall = 1'b1;
                held++;
                nVec++;
                if ({ser_bit, ser_recving, ser_start, ser_pkttype} !== {expB[12], 3'b100}) begin
                    nBad++; $display("FAIL stall_frozen: got %b expected %b",
                        {ser_bit, ser_recving, ser_start, ser_pkttype}, {expB[12], 3'b100});
                end
            end else begin
                stall = 1'b0;
                b[idx] = ser_bit; s[idx] = ser_start; r[idx] = ser_recving;
                idx++;
            end
            @(negedge clk);
        end
        stall = 1'b0;
        nVec++; if (idx !== 19) begin nBad++; $display("FAIL stall_bit_count: got %0d expected 19", idx); end
        nVec++; if (b !== expB) begin nBad++; $display("FAIL stall_bits: got %h expected %h", b, expB); end
        nVec++; if (s !== 128'hFF) begin nBad++; $display("FAIL stall_start: got %h expected ff", s); end
        nVec++; if (r !== 128'h7FFFF) begin nBad++; $display("FAIL stall_recving: got %h expected 7ffff", r); end
        repeat (2) @(negedge clk);
        nVec++; if (pkt_done !== 1'b1) begin nBad++; $display("FAIL stall_done: got %b expected 1", pkt_done); end
        @(negedge clk);
    endtask

    task automatic test_crc_timeout();
        logic [127:0] b, s, r, t;
        int errAt;
        logic sawDone;
        crc_sending = 1'b1;
        sendDesc(2'b01, 4'b0011, 7'h00, 4'h0, 64'hFFFF_0000_A5A5_5A5A);
        collect(72, b, s, r, t);
        errAt = 0; sawDone = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            sawDone |= pkt_done;
            if (crc_err === 1'b1) begin
                errAt = k;
                break;
            end
            @(negedge clk);
        end
        nVec++; if (errAt !== 31) begin nBad++; $display("FAIL timeout_cycle: got %0d expected 31", errAt); end
        nVec++; if (sawDone !== 1'b0) begin nBad++; $display("FAIL timeout_no_done: got %b expected 0", sawDone); end
        @(negedge clk);
        nVec++;
        if ({pkt_ready, busy, pkt_done, crc_err} !== 4'b1000) begin
            nBad++; $display("FAIL timeout_idle: got %b expected 1000", {pkt_ready, busy, pkt_done, crc_err});
        end
        crc_sending = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        logic [127:0] b, s, r, t, expB;
        logic sawPulse;
        crc_sending = 1'b1;
        sendDesc(2'b01, 4'b0011, 7'h00, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        collect(28, b, s, r, t);
        rst_L = 1'b0;
        #1;
        nVec++;
        if ({ser_bit, ser_recving, ser_start, ser_pkttype, busy, pkt_done, crc_err} !== 7'b0) begin
            nBad++; $display("FAIL midreset_outputs: got %b expected 0000000",
                {ser_bit, ser_recving, ser_start, ser_pkttype, busy, pkt_done, crc_err});
        end
        @(negedge clk);
        rst_L = 1'b1;
        crc_sending = 1'b0;
        #1;
        nVec++;
        if ({pkt_ready, busy} !== 2'b10) begin
            nBad++; $display("FAIL midreset_release: got %b expected 10", {pkt_ready, busy});
        end
        sawPulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sawPulse |= pkt_done | crc_err;
        end
        nVec++; if (sawPulse !== 1'b0) begin nBad++; $display("FAIL midreset_no_pulse: got %b expected 0", sawPulse); end
        sendDesc(2'b00, 4'b1001, 7'h7A, 4'hC, 64'h0);
        collect(19, b, s, r, t);
        expB = '0; expB[18:0] = {4'hC, 7'h7A, 4'b0110, 4'b1001};
        nVec++; if (b !== expB) begin nBad++; $display("FAIL midreset_next_token: got %h expected %h", b, expB); end
        repeat (2) @(negedge clk);
        nVec++; if (pkt_done !== 1'b1) begin nBad++; $display("FAIL midreset_next_done: got %b expected 1", pkt_done); end
        @(negedge clk);
    endtask

    // Hard stop in case a scenario loses track of the DUT.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_token();
        test_data();
        test_handshake();
        test_back_to_back();
        test_token_stall();
        test_crc_timeout();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
